jls_frame_feeder: RTL and testbench

JLS_FRAME_FEEDER -- requirements
Module: jls_frame_feeder

---
 rtl/jls_pkg.sv | 43 ++++
 rtl/jls_lfsr16.sv | 28 ++
 rtl/jls_frame_feeder.sv | 144 ++++++++++++++
 tb/tb_jls_frame_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/jls_pkg.sv
// Shared types and constants for the JPEG-LS frame feeder: FSM states,
// bubble modes, accepted frame-size limits and the bubble LFSR polynomial.
package jls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_BUB,
    ST_PIX,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    BUB_NONE  = 2'd0,
    BUB_FIXED = 2'd1,
    BUB_RAND  = 2'd2,
    BUB_RSVD  = 2'd3
  } bub_mode_t;

  localparam logic [14:0] MIN_W = 15'd5;
  localparam logic [14:0] MAX_W = 15'd16384;
  localparam logic [13:0] MAX_H = 14'd16383;

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

  // Bubble cycles to insert before the next pixel.
  function automatic logic [3:0] bub_len(input bub_mode_t m, input logic [3:0] n,
                                         input logic [15:0] q);
    logic [15:0] d;
    d = {12'd0, n} + 16'd1;
    case (m)
      BUB_FIXED: return n;
      BUB_RAND:  return 4'(q % d);
      default:   return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/jls_lfsr16.sv
// Seedable, enable-gated 16-bit LFSR; o_nxt exposes the value the register
// takes on the next enabled edge so callers can look one step ahead.
module jls_lfsr16
  import jls_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_q,
  output logic [15:0] o_nxt
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;

  logic [15:0] r_q;

  assign o_q   = r_q;
  assign o_nxt = lfsr_step(r_q);

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= SEED_EFF;
    else if (i_en) r_q <= o_nxt;
  end

endmodule

// File: rtl/jls_frame_feeder.sv
// Frame feeder: emits an SOF header, then forwards w*h upstream pixels to the
// encoder with optional fixed/random bubbles, then a fixed idle gap.
module jls_frame_feeder
  import jls_pkg::*;
#(
  parameter int          XW         = 8,
  parameter int          SOF_CYCLES = 368,
  parameter int          GAP_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [14:0]   s_w,
  input  logic [13:0]   s_h,
  input  logic [1:0]    bub_mode,
  input  logic [3:0]    bub_n,
  input  logic          s_valid,
  input  logic [XW-1:0] s_x,
  output logic          s_ready,
  output logic          o_sof,
  output logic [13:0]   o_w,
  output logic [13:0]   o_h,
  output logic          o_e,
  output logic [XW-1:0] o_x,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [15:0] SOF_LD = 16'(SOF_CYCLES - 1);
  localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES - 1);

  state_t        r_state;
  bub_mode_t     r_mode;
  logic [3:0]    r_bn;
  logic [27:0]   r_pix;
  logic [15:0]   r_cnt;
  logic          r_sof, r_e, r_done, r_err;
  logic [13:0]   r_ow, r_oh;
  logic [XW-1:0] r_x;

  logic          w_size_ok, w_accept, w_lfsr_en;
  logic [15:0]   w_lfsr, w_lfsr_nxt;
  logic [3:0]    w_k_first, w_k_next;
  bub_mode_t     w_mode_in;

  assign w_size_ok = (s_w >= MIN_W) && (s_w <= MAX_W) && (s_h != 14'd0) && (s_h <= MAX_H);
  assign s_ready   = (r_state == ST_PIX) && !rst;
  assign w_accept  = s_ready && s_valid;
  assign w_lfsr_en = w_accept && (r_mode == BUB_RAND);
  assign w_mode_in = (bub_mode == 2'd3) ? BUB_NONE : bub_mode_t'(bub_mode);
  // First pixel uses the current LFSR; later pixels see it after this accept's step.
  assign w_k_first = bub_len(r_mode, r_bn, w_lfsr);
  assign w_k_next  = bub_len(r_mode, r_bn, w_lfsr_nxt);

  jls_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_lfsr_en),
    .o_q   (w_lfsr),
    .o_nxt (w_lfsr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= BUB_NONE;
      r_bn    <= '0;
      r_pix   <= '0;
      r_cnt   <= '0;
      r_sof   <= 1'b0;
      r_ow    <= '0;
      r_oh    <= '0;
      r_e     <= 1'b0;
      r_x     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_e    <= w_accept;
      r_x    <= w_accept ? s_x : '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          if (w_size_ok) begin
            r_state <= ST_SOF;
            r_cnt   <= SOF_LD;
            r_mode  <= w_mode_in;
            r_bn    <= bub_n;
            r_pix   <= 28'(s_w) * 28'(s_h);
            r_sof   <= 1'b1;
            r_ow    <= 14'(s_w - 15'd1);
            r_oh    <= s_h - 14'd1;
          end else begin
            r_err <= 1'b1;
          end
        end
        ST_SOF: if (r_cnt == 16'd0) begin
          r_sof <= 1'b0;
          r_ow  <= '0;
          r_oh  <= '0;
          if (w_k_first == 4'd0) r_state <= ST_PIX;
          else begin
            r_state <= ST_BUB;
            r_cnt   <= {12'd0, w_k_first} - 16'd1;
          end
        end else r_cnt <= r_cnt - 16'd1;
        ST_BUB: if (r_cnt == 16'd0) r_state <= ST_PIX;
                else r_cnt <= r_cnt - 16'd1;
        ST_PIX: if (w_accept) begin
          r_pix <= r_pix - 28'd1;
          if (r_pix == 28'd1) begin
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_GAP;
              r_cnt   <= GAP_LD;
            end
          end else if (w_k_next != 4'd0) begin
            r_state <= ST_BUB;
            r_cnt   <= {12'd0, w_k_next} - 16'd1;
          end
        end
        ST_GAP: if (r_cnt == 16'd0) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end else r_cnt <= r_cnt - 16'd1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sof = r_sof;
  assign o_w   = r_ow;
  assign o_h   = r_oh;
  assign o_e   = r_e;
  assign o_x   = r_x;
  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_jls_frame_feeder.sv
// Randomized self-checking bench: a frame-level model predicts bubble lengths,
// pixel forwarding, SOF/GAP timing and done position for each frame.
module tb_jls_frame_feeder;

  localparam int          SOF  = 368;
  localparam int          GAP  = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready;
  logic [14:0] s_w;
  logic [13:0] s_h, o_w, o_h;
  logic [1:0]  bub_mode;
  logic [3:0]  bub_n;
  logic [7:0]  s_x, o_x;
  logic        o_sof, o_e, busy, done, err;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;

  jls_frame_feeder #(.XW(8), .SOF_CYCLES(SOF), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .s_w(s_w), .s_h(s_h), .bub_mode(bub_mode),
    .bub_n(bub_n), .s_valid(s_valid), .s_x(s_x), .s_ready(s_ready), .o_sof(o_sof),
    .o_w(o_w), .o_h(o_h), .o_e(o_e), .o_x(o_x), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference polynomial x^16+x^14+x^13+x^11+1, one step per mode-2 pixel.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic int exp_k(input int mode, input int n);
    if (mode == 1) return n;
    if (mode == 2) return int'(m_lfsr) % (n + 1);
    return 0;
  endfunction

  task automatic run_frame(input int w, input int h, input int mode, input int n,
                           input int stall_px, input int rst_px, input bit seq,
                           input bit rnd_v, input bit mid_start);
    int npix, cyc, px, sof_cnt, busy_cnt, oe_cnt, spur, dimbad, stall_cnt;
    int stall_left, sum_k, kk, bub_run, done_cyc, exp_len, quiet;
    bit need_k, exp_e, v, stalled;
    logic [7:0] exp_x, val;
    npix = w * h; cyc = 0; px = 0; sof_cnt = 0; busy_cnt = 0; oe_cnt = 0;
    spur = 0; dimbad = 0; stall_cnt = 0; stall_left = 0; bub_run = 0;
    done_cyc = -1; quiet = 0; exp_e = 0; stalled = 0; exp_x = '0;
    kk = exp_k(mode, n); sum_k = kk; need_k = 1;
    @(negedge clk);
    start = 1'b1; s_w = 15'(w); s_h = 14'(h); bub_mode = 2'(mode); bub_n = 4'(n);
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mid_start && cyc == SOF + 4) begin
        start = 1'b1; s_w = 15'd5; s_h = 14'd1;
      end
      if (exp_e) begin
        check("o_e", {31'd0, o_e}, 1);
        check("o_x", {24'd0, o_x}, {24'd0, exp_x});
        oe_cnt++;
      end else if (o_e !== 1'b0 || o_x !== 8'd0) spur++;
      exp_e = 0;
      if (o_sof) begin
        sof_cnt++;
        if (o_w !== 14'(w - 1) || o_h !== 14'(h - 1)) dimbad++;
      end else if (o_w !== 14'd0 || o_h !== 14'd0) dimbad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
      if (need_k && busy && !o_sof && !s_ready) bub_run++;
      s_valid = 1'($urandom);
      s_x = 8'($urandom);
      if (s_ready) begin
        if (need_k) begin
          check("bubble_len", bub_run, kk);
          need_k = 0;
        end
        if (px == rst_px) begin
          rst = 1'b1; s_valid = 1'b0;
          #1 check("rdy_in_rst", {31'd0, s_ready}, 0);
          @(negedge clk);
          rst = 1'b0;
          check("rst_outs", {o_sof, o_w, o_h, o_e, busy, done, err}, 0);
          check("rst_ox", {24'd0, o_x}, 0);
          m_lfsr = SEED;
          repeat (20) begin
            @(negedge clk);
            if (done || busy || o_e) quiet++;
          end
          check("rst_no_done", quiet, 0);
          return;
        end
        if (px == stall_px && !stalled) begin
          stalled = 1; stall_left = 10;
        end
        if (stall_left > 0) begin
          v = 0; stall_left--;
        end else v = rnd_v ? ($urandom % 4 != 0) : 1'b1;
        val = seq ? 8'(px + 1) : 8'($urandom);
        s_valid = v; s_x = val;
        if (v) begin
          exp_e = 1; exp_x = val; px++;
          if (mode == 2) m_lfsr = ref_lfsr(m_lfsr);
          if (px < npix) begin
            kk = exp_k(mode, n); sum_k += kk; need_k = 1; bub_run = 0;
          end
        end else stall_cnt++;
      end
    end
    s_valid = 1'b0;
    if (done_cyc < 0) check("timeout", 0, 1);
    exp_len = SOF + sum_k + stall_cnt + npix + GAP;
    check("done_at", done_cyc, exp_len + 1);
    check("busy_cycles", busy_cnt, exp_len);
    check("sof_cycles", sof_cnt, SOF);
    check("o_e_count", oe_cnt, npix);
    check("spurious_oe", spur, 0);
    check("sof_dims", dimbad, 0);
    check("busy_at_done", {31'd0, busy}, 0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 0);
    repeat (mid_start ? 400 : 10) begin
      @(negedge clk);
      if (busy || o_sof || done || err) quiet++;
    end
    check("idle_after", quiet, 0);
  endtask

  task automatic try_bad(input int w, input int h);
    int seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; s_w = 15'(w); s_h = 14'(h); bub_mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {31'd0, err}, 1);
    check("err_busy", {31'd0, busy | o_sof}, 0);
    repeat (5) begin
      @(negedge clk);
      if (err || busy || o_sof) seen++;
    end
    check("err_quiet", seen, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_x = '0;
    s_w = '0; s_h = '0; bub_mode = '0; bub_n = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {o_sof, o_w, o_h, o_e, busy, done, err, s_ready}, 0);
    check("reset_ox", {24'd0, o_x}, 0);
    rst = 1'b0;
    m_lfsr = SEED;

    run_frame(5, 1, 0, 0, -1, -1, 1, 0, 0);
    run_frame(6, 2, 1, 3, -1, -1, 0, 0, 0);
    run_frame(8, 8, 2, 2, -1, -1, 0, 0, 0);
    try_bad(4, 1);
    try_bad(16385, 1);
    try_bad(8, 0);
    run_frame(7, 3, 0, 0, 5, -1, 0, 0, 1);
    run_frame(8, 8, 2, 2, -1, 30, 0, 0, 0);
    run_frame(8, 8, 2, 2, -1, -1, 0, 0, 0);
    repeat (3)
      run_frame(5 + int'($urandom % 8), 1 + int'($urandom % 4), int'($urandom % 4),
                int'($urandom % 16), -1, -1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
